// File: rtl/core_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// core_sequencer : multi-cycle fetch/decode/execute/mem/writeback control FSM
// Revision       : 1.0
// ============================================================================
module core_sequencer #(
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned INSTR_CNT_W = 32
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_imem_ready,
  input  logic                   i_dmem_ready,
  input  logic                   i_mem_we,
  input  logic                   i_reg_we,
  input  logic                   i_load_instr,
  input  logic                   i_branch,
  input  logic                   i_jump,
  output logic                   o_imem_req,
  output logic                   o_instr_we,
  output logic                   o_dmem_req,
  output logic                   o_dmem_we,
  output logic                   o_reg_we,
  output logic                   o_pc_we,
  output logic                   o_branch_en,
  output logic                   o_jump_en,
  output logic [2:0]             o_state,
  output logic                   o_timeout,
  output logic [INSTR_CNT_W-1:0] o_instr_cnt
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_ERROR   = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic [TO_W-1:0]        wait_q, wait_d;
  logic                   store_q, store_d;
  logic                   regwe_q, regwe_d;
  logic                   load_q, load_d;
  logic                   branch_q, branch_d;
  logic                   jump_q, jump_d;
  logic [INSTR_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    store_d  = store_q;
    regwe_d  = regwe_q;
    load_d   = load_q;
    branch_d = branch_q;
    jump_d   = jump_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_FETCH: begin
        // A ready arriving on the final allowed wait cycle still wins.
        if (i_imem_ready)                   state_d = S_DECODE;
        else if (wait_q == TO_W'(TIMEOUT))  state_d = S_ERROR;
        else                                wait_d  = wait_q + 1'b1;
      end
      S_DECODE: begin
        store_d  = i_mem_we;
        regwe_d  = i_reg_we;
        load_d   = i_load_instr;
        branch_d = i_branch;
        jump_d   = i_jump;
        state_d  = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (load_q || store_q) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (i_dmem_ready)                   state_d = S_WB;
        else if (wait_q == TO_W'(TIMEOUT))  state_d = S_ERROR;
        else                                wait_d  = wait_q + 1'b1;
      end
      S_WB: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      store_q  <= 1'b0;
      regwe_q  <= 1'b0;
      load_q   <= 1'b0;
      branch_q <= 1'b0;
      jump_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      store_q  <= store_d;
      regwe_q  <= regwe_d;
      load_q   <= load_d;
      branch_q <= branch_d;
      jump_q   <= jump_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decode directly from the state register so reset clears them instantly.
  assign o_imem_req  = (state_q == S_FETCH);
  assign o_instr_we  = (state_q == S_FETCH) && i_imem_ready;
  assign o_dmem_req  = (state_q == S_MEM);
  assign o_dmem_we   = (state_q == S_MEM) && store_q;
  assign o_pc_we     = (state_q == S_WB);
  assign o_reg_we    = (state_q == S_WB) && regwe_q && !store_q && !branch_q;
  assign o_branch_en = (state_q == S_WB) && branch_q;
  assign o_jump_en   = (state_q == S_WB) && jump_q;
  assign o_state     = state_q;
  assign o_timeout   = (state_q == S_ERROR);
  assign o_instr_cnt = cnt_q;

endmodule
`default_nettype wire
